// File: rtl/led_counter_pkg.sv
// -----------------------------------------------------------------------------
// led_counter_pkg
// Shared constants and helpers for the LED up/down counter and its button
// debouncers.
//   - Overflow mode constants (wrap / saturate)
//   - Default debounce and auto-repeat timings
//   - lc_clog2(): counter width helper, usable in parameter expressions
//   - step_op_t: the per-cycle update decision made by the counter
// Optional feature macro used by the importing files: LED_COUNTER_AUTOREPEAT_EN
// -----------------------------------------------------------------------------
package led_counter_pkg;

    localparam int LC_MODE_WRAP = 1;
    localparam int LC_MODE_SAT  = 0;

    localparam int LC_DEFAULT_DEBOUNCE      = 16;
    localparam int LC_DEFAULT_REPEAT_DELAY  = 500;
    localparam int LC_DEFAULT_REPEAT_PERIOD = 100;

    // Number of bits needed to hold the values 0 .. value-1 (minimum 1).
    function automatic int lc_clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_INC   = 2'd1,
        OP_DEC   = 2'd2,
        OP_CLEAR = 2'd3
    } step_op_t;

endpackage

// File: rtl/led_updown_counter_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Conditions one raw asynchronous push-button into a clean press pulse.
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low
//   clear  : (LED_COUNTER_AUTOREPEAT_EN only) synchronous repeat-timer clear
//   raw    : raw active-high button pin
//   level  : debounced button level
//   press  : one-cycle pulse on each debounced 0->1 transition
//            (plus auto-repeat pulses when LED_COUNTER_AUTOREPEAT_EN is defined)
// The debounced level only follows the synchronised input after DEBOUNCE_CYCLES
// consecutive samples that disagree with it; any shorter run is discarded.
// -----------------------------------------------------------------------------
module button_debounce
    import led_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = LC_DEFAULT_DEBOUNCE
`ifdef LED_COUNTER_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = LC_DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = LC_DEFAULT_REPEAT_PERIOD
`endif
) (
    input  logic clock,
    input  logic reset,
`ifdef LED_COUNTER_AUTOREPEAT_EN
    input  logic clear,
`endif
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int DEB_W = lc_clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic             level_prev_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic             sample;
    logic             press_edge;

    assign sample = sync_q[1];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, exactly like the hardware.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q       <= 2'b00;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            deb_cnt_q    <= '0;
        end else begin
            sync_q       <= {sync_q[0], raw};
            level_prev_q <= level_q;
            if (sample == level_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                level_q   <= sample;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + DEB_W'(1);
            end
        end
    end

    assign press_edge = level_q & ~level_prev_q;
    assign level      = level_q;

`ifdef LED_COUNTER_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = lc_clog2(RPT_MAX + 1);

    // rpt_cnt_q holds the number of cycles since the last press/repeat pulse;
    // the first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_first_q;
    logic             repeat_fire;

    assign repeat_fire = level_q && !press_edge && !clear &&
                         (rpt_cnt_q == (rpt_first_q ? RPT_W'(REPEAT_DELAY)
                                                    : RPT_W'(REPEAT_PERIOD)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else if (clear || !level_q) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else if (press_edge) begin
            rpt_cnt_q   <= RPT_W'(1);
            rpt_first_q <= 1'b1;
        end else if (repeat_fire) begin
            rpt_cnt_q   <= RPT_W'(1);
            rpt_first_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_q + RPT_W'(1);
        end
    end

    assign press = press_edge | repeat_fire;
`else
    assign press = press_edge;
`endif

endmodule

// File: rtl/led_updown_counter.sv
// -----------------------------------------------------------------------------
// led_updown_counter
// Up/down counter stepped by two debounced push-buttons, shown on the LEDs.
//   clock           : system clock, rising edge
//   reset           : asynchronous, active-low
//   button_increase : raw active-high button, adds STEP per press
//   button_decrease : raw active-high button, subtracts STEP per press
//   clear           : synchronous, loads RESET_VALUE, beats both buttons
//   count / led     : registered counter value (same register)
//   at_max / at_min : count is all-ones / zero
//   wrap_pulse      : one cycle when a step wrapped (always 0 when WRAP=0)
// Optional auto-repeat of held buttons: define LED_COUNTER_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
module led_updown_counter
    import led_counter_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int STEP            = 1,
    parameter int WRAP            = LC_MODE_WRAP,
    parameter int DEBOUNCE_CYCLES = LC_DEFAULT_DEBOUNCE,
    parameter int RESET_VALUE     = 0
`ifdef LED_COUNTER_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = LC_DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = LC_DEFAULT_REPEAT_PERIOD
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             button_increase,
    input  logic             button_decrease,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] led,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_pulse
);

    localparam logic [WIDTH-1:0] RESET_LOAD = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH:0]   STEP_EXT   = (WIDTH + 1)'(STEP);

    logic             inc_press;
    logic             dec_press;
    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    step_op_t         op;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef LED_COUNTER_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_debounce_inc (
        .clock(clock),
        .reset(reset),
`ifdef LED_COUNTER_AUTOREPEAT_EN
        .clear(clear),
`endif
        .raw  (button_increase),
        .level(),
        .press(inc_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef LED_COUNTER_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_debounce_dec (
        .clock(clock),
        .reset(reset),
`ifdef LED_COUNTER_AUTOREPEAT_EN
        .clear(clear),
`endif
        .raw  (button_decrease),
        .level(),
        .press(dec_press)
    );

    // The extra top bit is the carry on increase and the borrow on decrease.
    assign sum_ext  = {1'b0, count_q} + STEP_EXT;
    assign diff_ext = {1'b0, count_q} - STEP_EXT;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        op         = OP_HOLD;
        next_count = count_q;
        next_wrap  = 1'b0;

        if (clear) begin
            op = OP_CLEAR;
        end else if (inc_press && dec_press) begin
            op = OP_HOLD;
        end else if (inc_press) begin
            op = OP_INC;
        end else if (dec_press) begin
            op = OP_DEC;
        end

        case (op)
            OP_CLEAR: next_count = RESET_LOAD;
            OP_INC: begin
                if (WRAP == LC_MODE_WRAP) begin
                    next_count = sum_ext[WIDTH-1:0];
                    next_wrap  = sum_ext[WIDTH];
                end else begin
                    next_count = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
                end
            end
            OP_DEC: begin
                if (WRAP == LC_MODE_WRAP) begin
                    next_count = diff_ext[WIDTH-1:0];
                    next_wrap  = diff_ext[WIDTH];
                end else begin
                    next_count = diff_ext[WIDTH] ? '0 : diff_ext[WIDTH-1:0];
                end
            end
            default: next_count = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= RESET_LOAD;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= next_count;
            wrap_q  <= next_wrap;
        end
    end

    assign count      = count_q;
    assign led        = count_q;
    assign at_max     = (count_q == {WIDTH{1'b1}});
    assign at_min     = (count_q == '0);
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_led_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_led_updown_counter
// Drives one wrapping and one saturating counter (WIDTH=4, STEP=3,
// DEBOUNCE_CYCLES=4, RESET_VALUE=5) from the same buttons and compares both
// against an arithmetic model every cycle. Button presses are turned into
// scheduled step events at (rise edge + DEBOUNCE_CYCLES + 3); glitches shorter
// than DEBOUNCE_CYCLES schedule nothing.
// -----------------------------------------------------------------------------
module tb_led_updown_counter;

    localparam int W    = 4;
    localparam int STEP = 3;
    localparam int DEB  = 4;
    localparam int RV   = 5;
    localparam int MAXV = (1 << W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic button_increase = 1'b0;
    logic button_decrease = 1'b0;
    logic clear = 1'b0;

    logic [W-1:0] count_w, led_w, count_s, led_s;
    logic at_max_w, at_min_w, wrap_pulse_w;
    logic at_max_s, at_min_s, wrap_pulse_s;

    led_updown_counter #(
        .WIDTH(W), .STEP(STEP), .WRAP(1), .DEBOUNCE_CYCLES(DEB), .RESET_VALUE(RV)
    ) u_wrap (
        .clock(clock), .reset(reset),
        .button_increase(button_increase), .button_decrease(button_decrease),
        .clear(clear), .count(count_w), .led(led_w),
        .at_max(at_max_w), .at_min(at_min_w), .wrap_pulse(wrap_pulse_w)
    );

    led_updown_counter #(
        .WIDTH(W), .STEP(STEP), .WRAP(0), .DEBOUNCE_CYCLES(DEB), .RESET_VALUE(RV)
    ) u_sat (
        .clock(clock), .reset(reset),
        .button_increase(button_increase), .button_decrease(button_decrease),
        .clear(clear), .count(count_s), .led(led_s),
        .at_max(at_max_s), .at_min(at_min_s), .wrap_pulse(wrap_pulse_s)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    bit run = 1'b0;

    // Scheduled effects, keyed by the rising edge at which they act.
    bit inc_at[int];
    bit dec_at[int];
    bit clr_at[int];

    int m_wrap = RV;
    int m_sat  = RV;
    int m_wp   = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, actual, expected, edge_cnt);
        end
    endtask

    always @(posedge clock) edge_cnt++;

    // Model update for the edge just passed, then compare on the falling edge.
    always @(negedge clock) begin
        if (run) begin
            bit i, d, c;
            i = inc_at.exists(edge_cnt);
            d = dec_at.exists(edge_cnt);
            c = clr_at.exists(edge_cnt);
            if (c) begin
                m_wrap = RV; m_sat = RV; m_wp = 0;
            end else if (i && d) begin
                m_wp = 0;
            end else if (i) begin
                m_wp   = (m_wrap + STEP > MAXV) ? 1 : 0;
                m_wrap = (m_wrap + STEP) % (MAXV + 1);
                m_sat  = (m_sat + STEP > MAXV) ? MAXV : m_sat + STEP;
            end else if (d) begin
                m_wp   = (m_wrap < STEP) ? 1 : 0;
                m_wrap = (m_wrap - STEP + MAXV + 1) % (MAXV + 1);
                m_sat  = (m_sat < STEP) ? 0 : m_sat - STEP;
            end else begin
                m_wp = 0;
            end
            check("wrap_count",  count_w,      m_wrap);
            check("wrap_led",    led_w,        m_wrap);
            check("wrap_at_max", at_max_w,     (m_wrap == MAXV) ? 1 : 0);
            check("wrap_at_min", at_min_w,     (m_wrap == 0) ? 1 : 0);
            check("wrap_pulse",  wrap_pulse_w, m_wp);
            check("sat_count",   count_s,      m_sat);
            check("sat_led",     led_s,        m_sat);
            check("sat_at_max",  at_max_s,     (m_sat == MAXV) ? 1 : 0);
            check("sat_at_min",  at_min_s,     (m_sat == 0) ? 1 : 0);
            check("sat_pulse",   wrap_pulse_s, 0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raise the selected buttons (dec delayed by dec_offset cycles), hold each
    // for hold cycles, release, then idle long enough for the levels to settle.
    task automatic buttons(input bit inc_en, input bit dec_en, input int dec_offset, input int hold);
        int span;
        span = dec_en ? dec_offset + hold : hold;
        for (int k = 0; k < span; k++) begin
            tick();
            button_increase = inc_en && (k < hold);
            button_decrease = dec_en && (k >= dec_offset) && (k < dec_offset + hold);
            if (inc_en && k == 0 && hold >= DEB) inc_at[edge_cnt + DEB + 3] = 1'b1;
            if (dec_en && k == dec_offset && hold >= DEB) dec_at[edge_cnt + DEB + 3] = 1'b1;
        end
        tick();
        button_increase = 1'b0;
        button_decrease = 1'b0;
        repeat (DEB + 4) tick();
    endtask

    task automatic pulse_clear();
        tick();
        clear = 1'b1;
        clr_at[edge_cnt + 1] = 1'b1;
        tick();
        clear = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        int n;
        int before_w, before_s;

        // Reset state, held asynchronously across several edges.
        repeat (3) tick();
        check("rst_count_w", count_w, 5);
        check("rst_led_w",   led_w,   5);
        check("rst_at_min",  at_min_w, 0);
        check("rst_at_max",  at_max_w, 0);
        check("rst_pulse",   wrap_pulse_w, 0);
        check("rst_count_s", count_s, 5);
        reset = 1'b1;
        run   = 1'b1;
        repeat (3) tick();

        // A 3-cycle glitch must not step the counter.
        buttons(1'b1, 1'b0, 0, DEB - 1);
        check("glitch_count", count_w, 5);

        // Clean press held 10 cycles: step lands exactly on edge 7.
        tick();
        button_increase = 1'b1;
        n = edge_cnt;
        inc_at[n + DEB + 3] = 1'b1;
        while (edge_cnt < n + DEB + 2) tick();
        check("latency_edge6", count_w, 5);
        tick();
        check("latency_edge7", count_w, 8);
        while (edge_cnt < n + 10) tick();
        button_increase = 1'b0;
        repeat (DEB + 4) tick();
        check("release_nochange", count_w, 8);

        // Two more presses, then clear.
        buttons(1'b1, 1'b0, 0, DEB + 2);
        buttons(1'b1, 1'b0, 0, DEB);
        check("lit_14_w", count_w, 14);
        check("lit_14_s", count_s, 14);
        pulse_clear();
        check("clear_w", count_w, 5);
        check("clear_s", count_s, 5);

        // Overflow at 14 + 3.
        repeat (3) buttons(1'b1, 1'b0, 0, DEB + 1);
        buttons(1'b1, 1'b0, 0, DEB + 1);
        check("ovf_wrap", count_w, 1);
        check("ovf_sat",  count_s, 15);
        check("ovf_sat_max", at_max_s, 1);
        check("model_ovf_wrap", m_wrap, 1);
        check("model_ovf_sat",  m_sat, 15);

        // Underflow 1 - 3 on the wrapping counter.
        buttons(1'b0, 1'b1, 0, DEB + 1);
        check("udf_wrap", count_w, 14);
        check("dec_sat",  count_s, 12);

        // Saturate at zero from 2.
        pulse_clear();
        buttons(1'b0, 1'b1, 0, DEB + 3);
        check("dec_to_2_s", count_s, 2);
        buttons(1'b0, 1'b1, 0, DEB + 3);
        check("sat_zero", count_s, 0);
        check("sat_zero_min", at_min_s, 1);
        check("wrap_from_2", count_w, 15);
        check("model_sat_zero", m_sat, 0);

        // Simultaneous presses cancel; offset presses step up then down.
        before_w = m_wrap;
        before_s = m_sat;
        buttons(1'b1, 1'b1, 0, DEB + 2);
        check("both_same_w", count_w, before_w);
        check("both_same_s", count_s, before_s);
        buttons(1'b1, 1'b1, 1, DEB + 2);
        check("both_offset_w", count_w, before_w);

        // Randomised traffic.
        for (int r = 0; r < 60; r++) begin
            int op, hold;
            op   = $urandom_range(0, 5);
            hold = (op == 4) ? $urandom_range(1, DEB - 1) : $urandom_range(DEB, DEB + 6);
            case (op)
                0: buttons(1'b1, 1'b0, 0, hold);
                1: buttons(1'b0, 1'b1, 0, hold);
                2: buttons(1'b1, 1'b1, 0, hold);
                3: buttons(1'b1, 1'b1, $urandom_range(1, 3), hold);
                4: buttons($urandom_range(0, 1) == 1, 1'b0, 0, hold);
                default: pulse_clear();
            endcase
        end

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
